// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated adder: FSM states and
// the requester-ID width helper.
package add_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // A single requester still needs a 1-bit ID port
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/add_arbiter_adder.sv
// Plain n-bit ripple-carry adder shared by all requesters of add_arbiter.
module n_bit_adder #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         cout
);

  logic [n:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < n; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[n];

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one ripple adder among NREQ requesters;
// one operation in flight at a time (IDLE -> CALC -> RESP).
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_sum,
  output logic              rsp_carry,
  output logic [ID_W-1:0]   rsp_id
);

  arb_state_t      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic            cin_r;
  logic [ID_W-1:0] id_r;
  logic [N-1:0]    sum_w;
  logic            cout_w;

  // Scan from the farthest candidate back to ptr so the nearest valid one wins
  always_comb begin
    int cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_any) req_ready[grant_idx] = 1'b1;
  end

  n_bit_adder #(.n(N)) u_adder (
    .a   (a_r),
    .b   (b_r),
    .cin (cin_r),
    .sum (sum_w),
    .cout(cout_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      cin_r     <= 1'b0;
      id_r      <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            a_r   <= req_a[grant_idx*N +: N];
            b_r   <= req_b[grant_idx*N +: N];
            cin_r <= req_cin[grant_idx];
            id_r  <= grant_idx;
            ptr   <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
            state <= CALC;
          end
        end
        CALC: begin
          rsp_sum   <= sum_w;
          rsp_carry <= cout_w;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized scoreboard bench for add_arbiter (N=8, NREQ=4) with a
// transaction-level round-robin reference model.
module tb_add_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_sum;
  logic        rsp_carry;
  logic [1:0]  rsp_id;

  add_arbiter #(.N(8), .NREQ(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_cin  (req_cin),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_carry(rsp_carry),
    .rsp_id   (rsp_id)
  );

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic [1:0] id;
    int         gcyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         model_ptr = 0;
  bit         model_busy = 0;
  logic [7:0] opa[4];
  logic [7:0] opb[4];
  logic [3:0] opc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic packOperands();
    for (int k = 0; k < 4; k++) begin
      req_a[k*8 +: 8] = opa[k];
      req_b[k*8 +: 8] = opb[k];
    end
    req_cin = opc;
  endtask

  // One cycle of stimulus; the model decides whether a grant must happen now
  task automatic applyStimulus(input logic [3:0] v, input logic rr);
    logic [3:0] exp_ready;
    int         g;
    int         tot;
    exp_t       e;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = v;
    rsp_ready = rr;
    packOperands();
    #1;
    exp_ready = '0;
    g = -1;
    if (!model_busy) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (model_ptr + k) % 4;
        if (g < 0 && v[c]) g = c;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) begin
      tot     = int'(opa[g]) + int'(opb[g]) + int'(opc[g]);
      e.sum   = 8'(tot % 256);
      e.carry = (tot >= 256);
      e.id    = 2'(g);
      e.gcyc  = cyc;
      sb.push_back(e);
      model_ptr  = (g + 1) % 4;
      model_busy = 1;
    end
  endtask

  task automatic doReset(input int ncyc);
    @(negedge clk);
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    rsp_ready  = 1'b1;
    sb.delete();
    model_busy = 0;
    model_ptr  = 0;
    #1;
    checkOutput("reset_req_ready", 64'(req_ready), 64'h0);
    checkOutput("reset_rsp_sum", 64'(rsp_sum), 64'h0);
    checkOutput("reset_rsp_carry", 64'(rsp_carry), 64'h0);
    checkOutput("reset_rsp_id", 64'(rsp_id), 64'h0);
    repeat (ncyc - 1) @(negedge clk);
  endtask

  task automatic setOp(input int k, input logic [7:0] a, input logic [7:0] b, input logic c);
    opa[k] = a;
    opb[k] = b;
    opc[k] = c;
  endtask

  // Monitor: compares presented responses against the head of the scoreboard
  initial begin
    bit prev_valid;
    int rise_cyc;
    prev_valid = 0;
    rise_cyc   = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n !== 1'b1) begin
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        prev_valid = 0;
      end else if (rsp_valid) begin
        if (!prev_valid) rise_cyc = cyc;
        prev_valid = 1;
        if (sb.size() == 0) begin
          checkOutput("spurious_rsp_valid", 64'(rsp_valid), 64'h0);
        end else begin
          checkOutput("rsp_sum", 64'(rsp_sum), 64'(sb[0].sum));
          checkOutput("rsp_carry", 64'(rsp_carry), 64'(sb[0].carry));
          checkOutput("rsp_id", 64'(rsp_id), 64'(sb[0].id));
          if (rsp_ready) begin
            checkOutput("rsp_latency", 64'(rise_cyc), 64'(sb[0].gcyc + 2));
            void'(sb.pop_front());
            model_busy = 0;
            prev_valid = 0;
          end
        end
      end else begin
        prev_valid = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) setOp(k, 8'h00, 8'h00, 1'b0);
    packOperands();
    doReset(3);

    // Single request with wrap-around carry
    setOp(2, 8'hFF, 8'h01, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    repeat (3) applyStimulus(4'b0000, 1'b1);

    // Carry-in sensitivity
    setOp(0, 8'h7F, 8'h80, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    repeat (3) applyStimulus(4'b0000, 1'b1);
    setOp(0, 8'h7F, 8'h80, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    repeat (3) applyStimulus(4'b0000, 1'b1);

    // All requesters valid from reset: strict rotation every 3 cycles
    doReset(2);
    for (int k = 0; k < 4; k++) setOp(k, 8'(8'h10 * k + 3), 8'(8'hF0 - k), 1'(k));
    repeat (18) applyStimulus(4'b1111, 1'b1);

    // Backpressure in RESP with other requesters waiting
    applyStimulus(4'b0000, 1'b1);
    repeat (4) applyStimulus(4'b0000, 1'b1);
    setOp(1, 8'hA5, 8'h5A, 1'b1);
    applyStimulus(4'b0010, 1'b0);
    repeat (7) applyStimulus(4'b1111, 1'b0);
    repeat (6) applyStimulus(4'b1111, 1'b1);
    repeat (4) applyStimulus(4'b0000, 1'b1);

    // Reset mid-CALC, then simultaneous requests 3 and 0
    applyStimulus(4'b0100, 1'b1);
    doReset(2);
    setOp(0, 8'h11, 8'h22, 1'b0);
    setOp(3, 8'h33, 8'h44, 1'b1);
    applyStimulus(4'b1001, 1'b1);
    repeat (3) applyStimulus(4'b0000, 1'b1);

    // Short-lived request during RESP is never granted
    setOp(2, 8'h01, 8'h02, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    repeat (4) applyStimulus(4'b0000, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) setOp(k, 8'($urandom), 8'($urandom), 1'($urandom));
      applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    // Drain outstanding responses within a bounded window
    for (int i = 0; i < 10 && sb.size() != 0; i++) applyStimulus(4'b0000, 1'b1);
    checkOutput("drain_outstanding", 64'(sb.size()), 64'h0);
    repeat (2) applyStimulus(4'b0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter N, default 8, operand and sum width in bits (1..64).
REQ-002 Parameter NREQ, default 4, number of requesters (2..8); ID_W = clog2(NREQ).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  bit k: requester k presents an operation.
REQ-006 req_ready  output  NREQ  bit k: requester k's operation accepted this cycle.
REQ-007 req_a  input  NREQ*N  packed operand A; requester k in bits [k*N +: N].
REQ-008 req_b  input  NREQ*N  packed operand B; same packing as req_a.
REQ-009 req_cin  input  NREQ  carry-in per requester.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_sum  output  N  registered sum.
REQ-013 rsp_carry  output  1  registered carry-out.
REQ-014 rsp_id  output  ID_W  index of the requester that owns the result.

Function
REQ-015 The block SHALL share one N-bit ripple adder among NREQ requesters through a three-state FSM: IDLE, CALC, RESP.
REQ-016 In IDLE with any req_valid set, the block SHALL grant the first valid requester at or after pointer ptr, wrapping modulo NREQ, and go to CALC.
REQ-017 req_ready SHALL be combinational, asserted only in IDLE, one-hot for the granted index, and all zero otherwise.
REQ-018 On grant, the block SHALL register a, b, cin and the granted ID, and SHALL set ptr to (grant+1) mod NREQ.
REQ-019 In CALC, the block SHALL register sum = (a+b+cin) mod 2^N and carry = bit N of the (N+1)-bit total, then go to RESP.
REQ-020 In RESP, rsp_valid SHALL be 1; on rsp_valid&&rsp_ready the block SHALL return to IDLE.
REQ-021 Latency: for a grant in cycle T, rsp_valid SHALL rise in cycle T+2; minimum spacing between grants is 3 cycles.
REQ-022 rsp_sum, rsp_carry and rsp_id SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-023 A requester that deasserts req_valid before being granted SHALL never receive req_ready; no operation is recorded for it.
REQ-024 req_valid asserted during CALC or RESP SHALL be ignored until the next IDLE cycle.
REQ-025 Round-robin SHALL be starvation-free: a continuously valid requester SHALL be granted within NREQ grants.

Reset
REQ-026 While rst_n=0: state=IDLE, ptr=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, req_ready=0.
REQ-027 Reset asserted in CALC or RESP SHALL discard the in-flight operation; no rsp_valid for it after release.
REQ-028 The first cycle after reset release SHALL behave as IDLE with ptr=0.

Structure
REQ-029 The FSM state encoding (IDLE/CALC/RESP) and the ID_W width helper SHALL live in shared package add_arb_pkg.
REQ-030 The adder SHALL be one instance of the existing n_bit_adder sub-module with n=N; no other arithmetic on the datapath.
REQ-031 Grant selection SHALL be combinational off ptr and req_valid; all outputs except req_ready SHALL be registered.

Verification (N=8, NREQ=4)
REQ-032 Single request: req 2 valid, a=0xFF, b=0x01, cin=0, rsp_ready=1 -> req_ready=0b0100 at T; at T+2: rsp_sum=0x00, rsp_carry=1, rsp_id=2.
REQ-033 Carry-in: req 0, a=0x7F, b=0x80, cin=1 -> rsp_sum=0x00, rsp_carry=1; with cin=0 -> rsp_sum=0xFF, rsp_carry=0.
REQ-034 All four valid continuously from reset -> grant order 0,1,2,3,0,1; every grant separated by exactly 3 cycles.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable and req_ready=0 throughout; the next grant comes in the cycle after acceptance.
REQ-036 Reset mid-CALC -> rsp_valid stays 0 after release; requesters 3 and 0 valid together -> 0 granted first.
REQ-037 Requester 1 valid for 1 cycle during RESP, then low -> never granted; ptr unchanged.
